// File: rtl/pueo_thresh_pkg.sv
// Shared definitions for the dual-beam threshold servo: FSM states, widths,
// threshold-CE encodings and the power-on threshold.
package pueo_thresh_pkg;

  localparam int THRESH_BITS = 18;

  localparam logic [1:0] CE_A = 2'b10;
  localparam logic [1:0] CE_B = 2'b01;

  localparam logic [THRESH_BITS-1:0] THRESH_SAFE = 18'h3FFFF;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    LOAD_A,
    LOAD_B,
    UPDATE,
    RUN
  } state_t;

endpackage

// File: rtl/thresh_step_sat.sv
// Combinational compare-and-step: moves a threshold by one step toward the
// target trigger count, saturating at zero and at full scale.
module thresh_step_sat #(
  parameter int THRESH_BITS = 18,
  parameter int COUNT_BITS  = 17
) (
  input  logic [THRESH_BITS-1:0] thresh,
  input  logic [COUNT_BITS-1:0]  count,
  input  logic [COUNT_BITS-1:0]  target,
  input  logic [THRESH_BITS-1:0] step,
  output logic [THRESH_BITS-1:0] next_thresh
);

  logic [THRESH_BITS:0] sum;

  assign sum = {1'b0, thresh} + {1'b0, step};

  always_comb begin
    next_thresh = thresh;
    if (count > target) begin
      next_thresh = sum[THRESH_BITS] ? '1 : sum[THRESH_BITS-1:0];
    end else if (count < target) begin
      next_thresh = (thresh < step) ? '0 : thresh - step;
    end
  end

endmodule

// File: rtl/dual_beam_thresh_servo.sv
// Closed-loop threshold servo: counts per-beam triggers over a fixed window,
// steps each beam threshold toward the target rate and reloads the beamformer.
module dual_beam_thresh_servo #(
  parameter int THRESH_BITS   = pueo_thresh_pkg::THRESH_BITS,
  parameter int WINDOW_CYCLES = 65536,
  parameter int COUNT_BITS    = 17,
  parameter int STEP          = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             trigger_i,
  input  logic                   enable_i,
  input  logic [THRESH_BITS-1:0] init_thresh_i,
  input  logic [COUNT_BITS-1:0]  target_i,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [1:0]             thresh_ce_o,
  output logic                   update_o,
  output logic [THRESH_BITS-1:0] thresh_a_o,
  output logic [THRESH_BITS-1:0] thresh_b_o,
  output logic                   busy_o
);
  import pueo_thresh_pkg::*;

  localparam int WIN_BITS = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_BITS-1:0]   WIN_LAST = WIN_BITS'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] CNT_MAX  = '1;

  state_t state_reg, state_next;
  logic [WIN_BITS-1:0]    win_reg;
  logic                   run_reg, abort_reg;
  logic                   counting, win_last;
  logic [THRESH_BITS-1:0] thresh_reg;
  logic [1:0]             ce_reg;
  logic                   update_reg;
  // Index 1 = beam A, index 0 = beam B, matching trigger_i bit order.
  logic [1:0][THRESH_BITS-1:0] thr_q, thr_nxt;

  // Counting starts with the first RUN cycle and then stays gap-free through
  // EVAL and the load states until the servo returns to IDLE.
  assign counting = (state_reg == RUN) || run_reg;
  assign win_last = counting && (win_reg == WIN_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable_i) state_next = LOAD_A;
      RUN:     if (!enable_i) state_next = IDLE;
               else if (win_last) state_next = EVAL;
      EVAL:    state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = UPDATE;
      UPDATE:  state_next = (abort_reg || !enable_i) ? IDLE : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      win_reg   <= '0;
      run_reg   <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == IDLE) begin
        win_reg   <= '0;
        run_reg   <= 1'b0;
        abort_reg <= 1'b0;
      end else begin
        if (counting) win_reg <= win_last ? '0 : win_reg + WIN_BITS'(1);
        run_reg   <= run_reg || (state_reg == RUN);
        abort_reg <= abort_reg || (!enable_i && state_reg inside {EVAL, LOAD_A, LOAD_B});
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_beam
    logic [COUNT_BITS-1:0]  cnt_reg, snap_reg, cnt_inc;
    logic [THRESH_BITS-1:0] thr_reg, thr_step, thr_next;

    assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + COUNT_BITS'(trigger_i[gi]);

    thresh_step_sat #(
      .THRESH_BITS (THRESH_BITS),
      .COUNT_BITS  (COUNT_BITS)
    ) u_step (
      .thresh      (thr_reg),
      .count       (snap_reg),
      .target      (target_i),
      .step        (THRESH_BITS'(STEP)),
      .next_thresh (thr_step)
    );

    always_comb begin
      thr_next = thr_reg;
      if (state_reg == IDLE && enable_i) thr_next = init_thresh_i;
      else if (state_reg == EVAL)        thr_next = thr_step;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_reg  <= '0;
        snap_reg <= '0;
        thr_reg  <= THRESH_BITS'(THRESH_SAFE);
      end else begin
        thr_reg <= thr_next;
        if (state_next == IDLE) begin
          cnt_reg <= '0;
        end else if (counting) begin
          cnt_reg <= win_last ? '0 : cnt_inc;
          if (win_last) snap_reg <= cnt_inc;
        end
      end
    end

    assign thr_q[gi]   = thr_reg;
    assign thr_nxt[gi] = thr_next;
  end

  // Load-interface outputs are registered off the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thresh_reg <= '0;
      ce_reg     <= '0;
      update_reg <= 1'b0;
    end else begin
      ce_reg     <= '0;
      update_reg <= 1'b0;
      case (state_next)
        LOAD_A: begin
          thresh_reg <= thr_nxt[1];
          ce_reg     <= CE_A;
        end
        LOAD_B: begin
          thresh_reg <= thr_q[0];
          ce_reg     <= CE_B;
        end
        UPDATE:  update_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign thresh_o    = thresh_reg;
  assign thresh_ce_o = ce_reg;
  assign update_o    = update_reg;
  assign thresh_a_o  = thr_q[1];
  assign thresh_b_o  = thr_q[0];
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: doc/dual_beam_thresh_servo.md
# dual_beam_thresh_servo

Closed-loop threshold controller for the dual-beam trigger. It counts the two `trigger` outputs of `dual_pueo_beam` over a fixed window and nudges each beam's threshold up or down by a fixed step toward a target count per window. It then loads both new thresholds back into `dual_pueo_beam` over its `thresh_i` / `thresh_ce_i` / `update_i` load interface. It sits between the beamformer's trigger outputs and its threshold inputs, in the same clock domain.

## Interface
- `THRESH_BITS`, default 18: threshold width; matches `dual_pueo_beam.thresh_i`.
- `WINDOW_CYCLES`, default 65536: counting window length in clocks; must be ≥ 8.
- `COUNT_BITS`, default 17: per-beam trigger counter width; counters saturate.
- `STEP`, default 16: threshold adjustment per window.
- `clk_i`  in  1: trigger-domain clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `trigger_i`  in  2: bit 1 = beam A, bit 0 = beam B; connect to `dual_pueo_beam.trigger_o`.
- `enable_i`  in  1: servo enable, level-sensitive.
- `init_thresh_i`  in  THRESH_BITS: starting threshold for both beams, sampled on enable.
- `target_i`  in  COUNT_BITS: desired triggers per window, common to both beams.
- `thresh_o`  out  THRESH_BITS: drives `thresh_i`.
- `thresh_ce_o`  out  2: drives `thresh_ce_i`; bit 1 = A, bit 0 = B.
- `update_o`  out  1: drives `update_i`.
- `thresh_a_o`, `thresh_b_o`  out  THRESH_BITS: current servo thresholds (status).
- `busy_o`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EVAL, LOAD_A, LOAD_B, UPDATE, RUN.
- Reset:
  - State goes to IDLE.
  - `thresh_o`, `thresh_ce_o`, `update_o` and `busy_o` = 0.
  - Internal A/B thresholds = all ones (`18'h3FFFF`), so `thresh_a_o` / `thresh_b_o` = `3FFFF`.
  - Counters = 0.
- IDLE, `enable_i`=1: both thresholds ← `init_thresh_i`; go to LOAD_A. The initial load skips EVAL.
- RUN: window counter increments each clock.
  - Each `trigger_i` bit adds 1 to its beam counter, saturating at `2^COUNT_BITS-1`.
  - On the terminal cycle (window counter = `WINDOW_CYCLES-1`):
    - snapshot = counter + that cycle's trigger bit, saturating;
    - counters and window counter clear;
    - go to EVAL.
- EVAL, per beam:
  - snapshot > `target_i`: threshold + `STEP`, saturating at `2^THRESH_BITS-1`.
  - snapshot < `target_i`: threshold − `STEP`, saturating at 0.
  - snapshot = `target_i`: threshold unchanged.
  - Then go to LOAD_A.
- Load sequence, one state per clock, outputs registered:
  - LOAD_A: `thresh_o`=A, `thresh_ce_o`=`2'b10`, `update_o`=0.
  - LOAD_B: `thresh_o`=B, `thresh_ce_o`=`2'b01`, `update_o`=0.
  - UPDATE: `thresh_o`=B (held), `thresh_ce_o`=`2'b00`, `update_o`=1.
  - Next state: RUN.
- Outside the load states, `thresh_ce_o`=0 and `update_o`=0. `thresh_o` holds its last value.
- The load sequence always runs, even when both thresholds are unchanged.
- The window counter and trigger counters keep running during EVAL and the load states. Window timing is therefore gap-free after the first window.
- `enable_i` falls:
  - In RUN: go to IDLE next clock.
  - In EVAL or a load state: finish through UPDATE, then go to IDLE, not RUN.
  - Entering IDLE clears all counters. Thresholds hold their values.
- `target_i` is sampled only in EVAL.
- A new enable re-applies `init_thresh_i`.

## Timing
- Terminal RUN cycle at T: EVAL at T+1, LOAD_A at T+2, LOAD_B at T+3, UPDATE at T+4, RUN from T+5.
- The beamformer sees new thresholds active after its `update_i` pipeline; that latency is outside this block.
- Enable sampled high in IDLE at cycle E: LOAD_A at E+1. The window counter starts at 0 in the first RUN cycle (E+4).
- `thresh_a_o` / `thresh_b_o` update at the EVAL→LOAD_A edge.
- `rst_i` asserted mid-sequence (e.g. during LOAD_B): all outputs return to reset values immediately and asynchronously. No partial `update_o` pulse is issued.

## Structure
- Shared package `pueo_thresh_pkg` holds:
  - the state enum;
  - `THRESH_BITS`;
  - CE encodings `CE_A=2'b10`, `CE_B=2'b01`;
  - the reset threshold `THRESH_SAFE=18'h3FFFF`.
- One sub-module, `thresh_step_sat`, instantiated twice (once per beam): a combinational compare-and-step with saturation. Inputs: threshold, count, target, `STEP`. Output: next threshold.

## Test plan
Parameters for all cases: `WINDOW_CYCLES`=64, `STEP`=16, `target_i`=4.

1. Reset, then idle 10 clocks with `enable_i`=0 → `thresh_o`=0, `thresh_ce_o`=0, `update_o`=0, `busy_o`=0; `thresh_a_o` = `thresh_b_o` = `3FFFF`.
2. `init_thresh_i`=`0x0F000`, raise `enable_i` at cycle E → E+1 `0F000`/`10`/0; E+2 `0F000`/`01`/0; E+3 `0F000`/`00`/1.
3. Beam A triggers every cycle, beam B silent for one window → A=`0x0F010`, B=`0x0EFF0`. The load sequence carries these values, with `update_o` at T+4.
4. Exactly 4 triggers on each beam in the window, including one on the terminal cycle → thresholds unchanged; the load sequence still occurs.
5. Saturation, A always triggering and B silent:
   - init `0x3FFF8` → A=`0x3FFFF`;
   - init `0x00008` → B=`0x00000`.
6. Reset pulse during LOAD_B → outputs 0 in the same cycle and state IDLE. Drop `enable_i` during LOAD_A → the sequence completes through UPDATE, then `busy_o`=0.
